// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw-command scheduler: opcode map, engine
// indices, command-word field layout, FSM state encoding and opcode decoder.
package draw_cmd_pkg;

  localparam int unsigned NUM_ENG  = 4;

  // Opcode occupies the top OPC_W bits of the command word; HALF_BIT is the
  // "full command" flag for the rectangle/char engines (0 = half-command).
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned HALF_BIT = 0;

  localparam logic [OPC_W-1:0] OP_PIXEL   = 4'h0;
  localparam logic [OPC_W-1:0] OP_RECT_SP = 4'h1;
  localparam logic [OPC_W-1:0] OP_RECT_PX = 4'h9;
  localparam logic [OPC_W-1:0] OP_CHAR    = 4'hA;

  localparam int unsigned ENG_PIXEL   = 0;
  localparam int unsigned ENG_RECT_SP = 1;
  localparam int unsigned ENG_RECT_PX = 2;
  localparam int unsigned ENG_CHAR    = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_ISSUE = 2'd2,
    S_BUSY  = 2'd3
  } state_e;

  typedef struct packed {
    logic               known;
    logic               half_ok;
    logic [NUM_ENG-1:0] sel;
  } op_dec_t;

  // Map an opcode onto its engine one-hot; half_ok marks opcodes that honour
  // the half-command bit.
  function automatic op_dec_t decode_op(input logic [OPC_W-1:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_PIXEL: begin
        d.known = 1'b1;
        d.sel[ENG_PIXEL] = 1'b1;
      end
      OP_RECT_SP: begin
        d.known = 1'b1;
        d.sel[ENG_RECT_SP] = 1'b1;
      end
      OP_RECT_PX: begin
        d.known   = 1'b1;
        d.half_ok = 1'b1;
        d.sel[ENG_RECT_PX] = 1'b1;
      end
      OP_CHAR: begin
        d.known   = 1'b1;
        d.half_ok = 1'b1;
        d.sel[ENG_CHAR] = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/draw_ram_port_mux.sv
// Single VGA RAM write port: registers the owning engine's address, data and
// write enable, and flags any write attempt from an engine that is not owner.
module draw_ram_port_mux
  import draw_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int COLOR_ID_WIDTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_ENG-1:0]                owner_i,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]     eng_addr_i,
  input  logic [NUM_ENG*COLOR_ID_WIDTH-1:0] eng_data_i,
  input  logic [NUM_ENG-1:0]                eng_wren_i,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic [COLOR_ID_WIDTH-1:0]         ram_data_o,
  output logic                              ram_wren_o,
  output logic                              wr_err_o
);

  logic [ADDR_WIDTH-1:0]     addr_d, ram_addr_q;
  logic [COLOR_ID_WIDTH-1:0] data_d, ram_data_q;
  logic                      wren_d, ram_wren_q;

  // Select the owner's slice; no owner drives an idle, zeroed bus.
  always_comb begin
    addr_d = '0;
    data_d = '0;
    wren_d = 1'b0;
    for (int unsigned k = 0; k < NUM_ENG; k++) begin
      if (owner_i[k]) begin
        addr_d = eng_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        data_d = eng_data_i[k*COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
        wren_d = eng_wren_i[k];
      end
    end
  end

  assign wr_err_o = |(eng_wren_i & ~owner_i);

  // One-cycle registered RAM port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
    end else begin
      ram_addr_q <= addr_d;
      ram_data_q <= data_d;
      ram_wren_q <= wren_d;
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_wren_o = ram_wren_q;

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Draw-command scheduler: pops the command FIFO, dispatches each command to
// one of four draw engines, waits for completion and owns the VGA RAM port.
// Optional watchdog on the BUSY wait: define DRAW_WDT_EN (adds err_wdt).
module draw_cmd_scheduler
  import draw_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 19,
  parameter int COLOR_ID_WIDTH = 8
`ifdef DRAW_WDT_EN
  ,
  parameter int                    WDT_WIDTH = 16,
  parameter logic [WDT_WIDTH-1:0]  WDT_LIMIT = 16'hFFFF
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic                              ff_empty,
  output logic                              ff_rden,
  input  logic [DATA_WIDTH-1:0]             ff_rdat,
  input  logic                              ff_rvld,
  output logic [DATA_WIDTH-1:0]             eng_cmd,
  output logic [NUM_ENG-1:0]                eng_vld,
  input  logic [NUM_ENG-1:0]                eng_done,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]     eng_addr,
  input  logic [NUM_ENG*COLOR_ID_WIDTH-1:0] eng_data,
  input  logic [NUM_ENG-1:0]                eng_wren,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [COLOR_ID_WIDTH-1:0]         ram_data,
  output logic                              ram_wren,
  output logic                              busy,
  output logic                              err_opcode,
  output logic                              err_bus
`ifdef DRAW_WDT_EN
  ,
  output logic                              err_wdt
`endif
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   cmd_q, cmd_d;
  logic [NUM_ENG-1:0]      owner_q, owner_d;
  logic [NUM_ENG-1:0]      cur_owner;
  logic                    err_opcode_q, err_bus_q;
  logic                    op_err_set, bus_err_set, mux_wr_err;
  logic                    half_cmd;
  op_dec_t                 dec;

`ifdef DRAW_WDT_EN
  logic [WDT_WIDTH-1:0]    wdt_q, wdt_d;
  logic                    err_wdt_q, wdt_fire;
`endif

  assign dec      = decode_op(cmd_q[DATA_WIDTH-1 -: OPC_W]);
  assign half_cmd = dec.half_ok & ~cmd_q[HALF_BIT];

  // During ISSUE the strobed engine already counts as owner, so its (illegal)
  // same-cycle done is ignored rather than reported as a bus error.
  assign cur_owner = (state_q == S_ISSUE) ? dec.sel : owner_q;

  // Next-state, FIFO strobe, engine strobe and owner tracking.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    ff_rden    = 1'b0;
    eng_vld    = '0;
    op_err_set = 1'b0;
`ifdef DRAW_WDT_EN
    wdt_d      = wdt_q;
    wdt_fire   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Owner lingers exactly one cycle into IDLE so a write issued in the
        // done cycle's wake still reaches the RAM port, then it is released.
        owner_d = '0;
        if (enb && !ff_empty) begin
          ff_rden = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (ff_rvld) begin
          cmd_d   = ff_rdat;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dec.known) begin
          eng_vld = dec.sel;
          owner_d = dec.sel;
          state_d = half_cmd ? S_IDLE : S_BUSY;
`ifdef DRAW_WDT_EN
          wdt_d   = '0;
`endif
        end else begin
          op_err_set = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_BUSY: begin
        if (|(eng_done & owner_q)) begin
          state_d = S_IDLE;
        end
`ifdef DRAW_WDT_EN
        else if (wdt_q == WDT_LIMIT - WDT_WIDTH'(1)) begin
          wdt_fire = 1'b1;
          owner_d  = '0;
          state_d  = S_IDLE;
        end else begin
          wdt_d = wdt_q + WDT_WIDTH'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, latched command and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      owner_q <= '0;
`ifdef DRAW_WDT_EN
      wdt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
`ifdef DRAW_WDT_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign bus_err_set = (|(eng_done & ~cur_owner)) | mux_wr_err;

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_opcode_q <= 1'b0;
      err_bus_q    <= 1'b0;
`ifdef DRAW_WDT_EN
      err_wdt_q    <= 1'b0;
`endif
    end else begin
      if (op_err_set)  err_opcode_q <= 1'b1;
      if (bus_err_set) err_bus_q    <= 1'b1;
`ifdef DRAW_WDT_EN
      if (wdt_fire)    err_wdt_q    <= 1'b1;
`endif
    end
  end

  draw_ram_port_mux #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .COLOR_ID_WIDTH (COLOR_ID_WIDTH)
  ) u_ram_mux (
    .clk_i      (clk),
    .rst_i      (rst),
    .owner_i    (owner_q),
    .eng_addr_i (eng_addr),
    .eng_data_i (eng_data),
    .eng_wren_i (eng_wren),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_data),
    .ram_wren_o (ram_wren),
    .wr_err_o   (mux_wr_err)
  );

  assign eng_cmd    = cmd_q;
  assign busy       = (state_q != S_IDLE);
  assign err_opcode = err_opcode_q;
  assign err_bus    = err_bus_q;
`ifdef DRAW_WDT_EN
  assign err_wdt    = err_wdt_q;
`endif

endmodule
